// File: rtl/ctrl_pkg.sv
// Shared constants and control-bundle type for the pipelined MIPS control unit.
// Holds opcode/Funct encodings, ALU codes, the E-stage bundle and its BUBBLE.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;

    // ALU code is kept at its native 4 bits; the top zero-extends to ALUC_W.
    typedef struct packed {
        logic       regWrite;
        logic       memtoReg;
        logic       memWrite;
        logic       aluSrc;
        logic       regDst;
        logic [3:0] aluCode;
        logic       mduStart;
        logic       hiLoRd;
        logic       hiSel;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/mdu_busy_counter.sv
// Multi-cycle MDU busy counter: loads MDU_LAT on start, then counts down to 0.
// Ports: clk, rst (sync, active-high), start in; busy, count out.
module mdu_busy_counter #(
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic [CNT_W-1:0] count
);

    // A start while still counting reloads; decrement saturates at 0.
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (start)
            count <= CNT_W'(MDU_LAT);
        else if (count != '0)
            count <= count - CNT_W'(1);
    end

    assign busy = (count != '0);

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined MIPS control: combinational D decode, bundle carried D->E->M->W,
// bubbles on stall/flush/illegal/MDU hazard. Ports: clk, rst, op, Funct,
// EqualD, StallD, FlushE in; D-stage flags, E/M/W controls, MduBusy out.
// Optional: define SHIFT_OPS_EN to decode sll/srl/sra.
module pipe_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int ALUC_W  = 4,
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        op,
    input  logic [5:0]        Funct,
    input  logic              EqualD,
    input  logic              StallD,
    input  logic              FlushE,
    output logic              PCSrcD,
    output logic              BranchD,
    output logic              SgnZeroD,
    output logic              IllegalD,
    output logic              MduStallD,
    output logic              RegWriteE,
    output logic              MemtoRegE,
    output logic              MemWriteE,
    output logic              ALUSrcE,
    output logic              RegDstE,
    output logic [ALUC_W-1:0] ALUControlE,
    output logic              MduStartE,
    output logic              HiLoRdE,
    output logic              HiSelE,
    output logic              RegWriteM,
    output logic              MemtoRegM,
    output logic              MemWriteM,
    output logic              RegWriteW,
    output logic              MemtoRegW,
    output logic              MduBusy
);

    ctrl_t            decD;
    ctrl_t            ctrlE;
    logic             isMduD;
    logic             bubbleE;
    logic [CNT_W-1:0] mduCount;

    always_comb begin
        decD     = BUBBLE;
        PCSrcD   = 1'b0;
        BranchD  = 1'b0;
        SgnZeroD = 1'b0;
        IllegalD = 1'b0;
        unique case (op)
            OP_RTYPE: begin
                unique case (Funct)
                    F_ADD, F_ADDU: begin
                        decD.regWrite = 1'b1;
                        decD.regDst   = 1'b1;
                        decD.aluCode  = ALU_ADD;
                    end
                    F_SUB, F_SUBU: begin
                        decD.regWrite = 1'b1;
                        decD.regDst   = 1'b1;
                        decD.aluCode  = ALU_SUB;
                    end
                    F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU: begin
                        decD.regWrite = 1'b1;
                        decD.regDst   = 1'b1;
                        unique case (Funct)
                            F_AND:   decD.aluCode = ALU_AND;
                            F_OR:    decD.aluCode = ALU_OR;
                            F_XOR:   decD.aluCode = ALU_XOR;
                            F_NOR:   decD.aluCode = ALU_NOR;
                            F_SLT:   decD.aluCode = ALU_SLT;
                            default: decD.aluCode = ALU_SLTU;
                        endcase
                    end
                    F_MULT, F_MULTU, F_DIV, F_DIVU: decD.mduStart = 1'b1;
                    F_MFHI, F_MFLO: begin
                        decD.regWrite = 1'b1;
                        decD.regDst   = 1'b1;
                        decD.hiLoRd   = 1'b1;
                        decD.hiSel    = (Funct == F_MFHI);
                    end
`ifdef SHIFT_OPS_EN
                    F_SLL, F_SRL, F_SRA: begin
                        decD.regWrite = 1'b1;
                        decD.regDst   = 1'b1;
                        unique case (Funct)
                            F_SLL:   decD.aluCode = ALU_SLL;
                            F_SRL:   decD.aluCode = ALU_SRL;
                            default: decD.aluCode = ALU_SRA;
                        endcase
                    end
`else
                    // The all-zero word stays a legal NOP.
                    F_SLL: decD = BUBBLE;
`endif
                    default: IllegalD = 1'b1;
                endcase
            end
            OP_LW: begin
                decD.regWrite = 1'b1;
                decD.memtoReg = 1'b1;
                decD.aluSrc   = 1'b1;
            end
            OP_SW: begin
                decD.memWrite = 1'b1;
                decD.aluSrc   = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                BranchD      = 1'b1;
                PCSrcD       = (op == OP_BEQ) ? EqualD : !EqualD;
                decD.aluCode = ALU_SUB;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                decD.regWrite = 1'b1;
                decD.aluSrc   = 1'b1;
                unique case (op)
                    OP_SLTI:  decD.aluCode = ALU_SLT;
                    OP_SLTIU: decD.aluCode = ALU_SLTU;
                    default:  decD.aluCode = ALU_ADD;
                endcase
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                // Logical immediates are zero-extended.
                SgnZeroD      = 1'b1;
                decD.regWrite = 1'b1;
                decD.aluSrc   = 1'b1;
                unique case (op)
                    OP_ANDI: decD.aluCode = ALU_AND;
                    OP_ORI:  decD.aluCode = ALU_OR;
                    default: decD.aluCode = ALU_XOR;
                endcase
            end
            default: IllegalD = 1'b1;
        endcase
    end

    // Any HI/LO user must wait for an MDU op in E or still counting.
    assign isMduD    = decD.mduStart | decD.hiLoRd;
    assign MduStallD = isMduD & ((mduCount != '0) | ctrlE.mduStart);
    assign bubbleE   = IllegalD | StallD | MduStallD | FlushE;

    always_ff @(posedge clk) begin
        if (rst || bubbleE)
            ctrlE <= BUBBLE;
        else
            ctrlE <= decD;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            RegWriteM <= 1'b0;
            MemtoRegM <= 1'b0;
            MemWriteM <= 1'b0;
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
        end else begin
            RegWriteM <= ctrlE.regWrite;
            MemtoRegM <= ctrlE.memtoReg;
            MemWriteM <= ctrlE.memWrite;
            RegWriteW <= RegWriteM;
            MemtoRegW <= MemtoRegM;
        end
    end

    mdu_busy_counter #(
        .MDU_LAT (MDU_LAT),
        .CNT_W   (CNT_W)
    ) uMduCnt (
        .clk   (clk),
        .rst   (rst),
        .start (ctrlE.mduStart),
        .busy  (MduBusy),
        .count (mduCount)
    );

    assign RegWriteE   = ctrlE.regWrite;
    assign MemtoRegE   = ctrlE.memtoReg;
    assign MemWriteE   = ctrlE.memWrite;
    assign ALUSrcE     = ctrlE.aluSrc;
    assign RegDstE     = ctrlE.regDst;
    assign ALUControlE = ALUC_W'(ctrlE.aluCode);
    assign MduStartE   = ctrlE.mduStart;
    assign HiLoRdE     = ctrlE.hiLoRd;
    assign HiSelE      = ctrlE.hiSel;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: directed steps then random traffic
// against a table-driven instruction model with a time-based MDU busy window.
module tb_pipe_ctrl_unit;

    localparam int ALUC_W  = 4;
    localparam int MDU_LAT = 4;
    localparam int CNT_W   = 4;

    logic clk, rst, EqualD, StallD, FlushE;
    logic [5:0] op, Funct;
    logic PCSrcD, BranchD, SgnZeroD, IllegalD, MduStallD;
    logic RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE;
    logic [ALUC_W-1:0] ALUControlE;
    logic MduStartE, HiLoRdE, HiSelE;
    logic RegWriteM, MemtoRegM, MemWriteM, RegWriteW, MemtoRegW, MduBusy;

    pipe_ctrl_unit #(.ALUC_W(ALUC_W), .MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .op(op), .Funct(Funct), .EqualD(EqualD),
        .StallD(StallD), .FlushE(FlushE), .PCSrcD(PCSrcD), .BranchD(BranchD),
        .SgnZeroD(SgnZeroD), .IllegalD(IllegalD), .MduStallD(MduStallD),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
        .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .ALUControlE(ALUControlE),
        .MduStartE(MduStartE), .HiLoRdE(HiLoRdE), .HiSelE(HiSelE),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
        .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .MduBusy(MduBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic rw, m2r, mw, src, dst;
        logic [3:0] alu;
        logic ms, hl, hs;
    } bun_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       r;
        bun_t       b;
        logic       br;
        logic       zx;
    } ins_t;

    ins_t tbl[$];
    int   nCmp = 0;
    int   nBad = 0;
    bun_t expE;
    logic [2:0] expM;
    logic [1:0] expW;
    int   edges;
    int   lastLoad;
    logic lastStallD;
    int   stallCnt;
    logic done;

    function automatic bun_t mk(logic rw, logic m2r, logic mw, logic src,
                                logic dst, int alu, logic ms, logic hl, logic hs);
        bun_t b;
        b = '{rw, m2r, mw, src, dst, 4'(alu), ms, hl, hs};
        return b;
    endfunction

    task automatic add(logic [5:0] o, logic [5:0] f, logic r, bun_t b,
                       logic br, logic zx);
        ins_t e;
        e.op = o; e.fn = f; e.r = r; e.b = b; e.br = br; e.zx = zx;
        tbl.push_back(e);
    endtask

    task automatic buildTable();
        logic [5:0] rf[10];
        int         ra[10];
        rf = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
        ra = '{0, 0, 1, 1, 2, 3, 4, 5, 6, 7};
        for (int i = 0; i < 10; i++)
            add(6'h00, rf[i], 1, mk(1, 0, 0, 0, 1, ra[i], 0, 0, 0), 0, 0);
        for (int i = 0; i < 4; i++)
            add(6'h00, 6'(24 + i), 1, mk(0, 0, 0, 0, 0, 0, 1, 0, 0), 0, 0);
        add(6'h00, 6'h10, 1, mk(1, 0, 0, 0, 1, 0, 0, 1, 1), 0, 0);
        add(6'h00, 6'h12, 1, mk(1, 0, 0, 0, 1, 0, 0, 1, 0), 0, 0);
`ifdef SHIFT_OPS_EN
        add(6'h00, 6'h00, 1, mk(1, 0, 0, 0, 1, 8, 0, 0, 0), 0, 0);
        add(6'h00, 6'h02, 1, mk(1, 0, 0, 0, 1, 9, 0, 0, 0), 0, 0);
        add(6'h00, 6'h03, 1, mk(1, 0, 0, 0, 1, 10, 0, 0, 0), 0, 0);
`else
        add(6'h00, 6'h00, 1, '0, 0, 0);
`endif
        add(6'h23, 6'h00, 0, mk(1, 1, 0, 1, 0, 0, 0, 0, 0), 0, 0);
        add(6'h2B, 6'h00, 0, mk(0, 0, 1, 1, 0, 0, 0, 0, 0), 0, 0);
        add(6'h04, 6'h00, 0, mk(0, 0, 0, 0, 0, 1, 0, 0, 0), 1, 0);
        add(6'h05, 6'h00, 0, mk(0, 0, 0, 0, 0, 1, 0, 0, 0), 1, 0);
        add(6'h08, 6'h00, 0, mk(1, 0, 0, 1, 0, 0, 0, 0, 0), 0, 0);
        add(6'h09, 6'h00, 0, mk(1, 0, 0, 1, 0, 0, 0, 0, 0), 0, 0);
        add(6'h0A, 6'h00, 0, mk(1, 0, 0, 1, 0, 6, 0, 0, 0), 0, 0);
        add(6'h0B, 6'h00, 0, mk(1, 0, 0, 1, 0, 7, 0, 0, 0), 0, 0);
        add(6'h0C, 6'h00, 0, mk(1, 0, 0, 1, 0, 2, 0, 0, 0), 0, 1);
        add(6'h0D, 6'h00, 0, mk(1, 0, 0, 1, 0, 3, 0, 0, 0), 0, 1);
        add(6'h0E, 6'h00, 0, mk(1, 0, 0, 1, 0, 4, 0, 0, 0), 0, 1);
    endtask

    task automatic lookup(input logic [5:0] o, input logic [5:0] f,
                          output bun_t b, output logic br,
                          output logic zx, output logic ill);
        b = '0; br = 0; zx = 0; ill = 1;
        foreach (tbl[i])
            if (tbl[i].op == o && (!tbl[i].r || tbl[i].fn == f)) begin
                b = tbl[i].b; br = tbl[i].br; zx = tbl[i].zx; ill = 0;
            end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0 ] exp);
        nCmp++;
        assert (obs === exp) else begin
            nBad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic busyNow();
        return (edges - lastLoad) < MDU_LAT;
    endfunction

    // Inputs are set just after a falling edge; this checks D, takes one
    // rising edge, updates the model and checks E/M/W.
    task automatic step();
        bun_t b;
        logic br, zx, ill, pc, stl, bub;
        #1;
        lookup(op, Funct, b, br, zx, ill);
        pc  = br ? (op[0] ? !EqualD : EqualD) : 1'b0;
        stl = (b.ms | b.hl) & (busyNow() | expE.ms);
        chk("D_flags", {PCSrcD, BranchD, SgnZeroD, IllegalD},
            {pc, br, zx, ill});
        chk("D_mduStall", MduStallD, stl);
        lastStallD = MduStallD;
        if (rst) begin
            expE = '0; expM = '0; expW = '0; lastLoad = -1000;
        end else begin
            bub = ill | StallD | stl | FlushE;
            if (expE.ms) lastLoad = edges + 1;
            expW = expM[2:1];
            expM = {expE.rw, expE.m2r, expE.mw};
            expE = bub ? '0 : b;
        end
        edges++;
        @(posedge clk);
        #1;
        chk("E_bundle", {RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE,
                         ALUControlE, MduStartE, HiLoRdE, HiSelE}, expE);
        chk("M_bundle", {RegWriteM, MemtoRegM, MemWriteM}, expM);
        chk("W_bundle", {RegWriteW, MemtoRegW}, expW);
        chk("MduBusy", MduBusy, busyNow());
        @(negedge clk);
    endtask

    initial begin
        rst = 1; op = 0; Funct = 0; EqualD = 0; StallD = 0; FlushE = 0;
        expE = '0; expM = '0; expW = '0; edges = 0; lastLoad = -1000;
        lastStallD = 0;
        buildTable();
        @(negedge clk);

        repeat (3) begin
            op = 6'($urandom); Funct = 6'($urandom);
            step();
        end
        chk("rst_regs", {RegWriteE, MemtoRegE, MemWriteE, MduStartE,
                         RegWriteM, MemWriteM, RegWriteW, MemtoRegW, MduBusy}, 0);
        rst = 0;

        op = 6'h23; Funct = 6'($urandom); step();
        op = 0; Funct = 0; step(); step();
        chk("lw_W", {RegWriteW, MemtoRegW}, 2'b11);

        op = 6'h04; EqualD = 1; #1;
        chk("beq_pc", {PCSrcD, BranchD}, 2'b11);
        step();
        op = 6'h05; #1;
        chk("bne_pc", PCSrcD, 0);
        step();
        EqualD = 0;

        op = 0; Funct = 6'h18; step();
        Funct = 6'h10; stallCnt = 0; done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            step();
            if (lastStallD) stallCnt++;
            else done = 1;
        end
        chk("mfhi_done", done, 1);
        chk("mfhi_stall", stallCnt, MDU_LAT + 1);
        chk("mfhi_E", {HiLoRdE, HiSelE, MduBusy}, 3'b110);
        Funct = 0; step();

        op = 6'h3F; #1;
        chk("ill_D", IllegalD, 1);
        step();
        chk("ill_E", {RegWriteE, MemWriteE, MduStartE, ALUControlE}, 0);

        op = 6'h2B; FlushE = 1; step();
        chk("flush_E", MemWriteE, 0);
        FlushE = 0; op = 0; Funct = 0; step();
        chk("flush_M", MemWriteM, 0);

        Funct = 6'h20; StallD = 1; FlushE = 1; step();
        chk("sf_bubble", RegWriteE, 0);
        StallD = 0; FlushE = 0; step();
        chk("sf_next", RegWriteE, 1);

        Funct = 6'h03; #1;
`ifdef SHIFT_OPS_EN
        step();
        chk("sra_alu", ALUControlE, 10);
`else
        chk("sra_ill", IllegalD, 1);
        step();
        chk("sra_rw", RegWriteE, 0);
`endif

        Funct = 6'h1A; step();
        Funct = 0; step();
        chk("mdu_busy", MduBusy, 1);
        rst = 1; step();
        chk("rst_mid", MduBusy, 0);
        rst = 0;

        for (int i = 0; i < 400; i++) begin
            int k;
            k = int'($urandom_range(0, tbl.size() - 1));
            if ($urandom_range(0, 4) == 0) begin
                op = 6'($urandom); Funct = 6'($urandom);
            end else begin
                op = tbl[k].op;
                Funct = tbl[k].r ? tbl[k].fn : 6'($urandom);
            end
            EqualD = 1'($urandom);
            StallD = ($urandom_range(0, 7) == 0);
            FlushE = ($urandom_range(0, 9) == 0);
            rst    = ($urandom_range(0, 39) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
